// File: rtl/oet_sort_stream.sv
// Streaming odd-even transposition sorter: loads N words, sorts them by key
// with early termination, then drains them in index order with valid/ready.
module oet_sort_stream #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 6,
    parameter int N          = 64,
    localparam int WIDTH     = ADDR_WIDTH + DATA_WIDTH,
    localparam int CNT_W     = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             descend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] phases_used
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic             ready_q;
    logic [IDX_W-1:0] load_cnt;
    logic [IDX_W-1:0] idx;
    logic             desc_q;
    logic             sort_done;
    logic             prev_quiet;
    logic [WIDTH-1:0] pe    [N];
    logic [WIDTH-1:0] pe_nx [N];
    logic             any_swap;
    logic             phase_end;
    logic             load_fire;
    logic             out_fire;
    logic             load_last;

    // ready_q stays low through the first edge after reset so no word is taken there
    assign in_ready  = ready_q && ((state_q == IDLE) || (state_q == LOAD));
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == SORT) || (state_q == DRAIN);
    assign out_data  = out_valid ? pe[idx] : '0;
    assign out_last  = out_valid && (idx == IDX_W'(N - 1));
    assign load_fire = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_last = load_fire && (load_cnt == IDX_W'(N - 1));

    // One compare-exchange phase; parity of the phase count selects the pairing
    always_comb begin
        any_swap = 1'b0;
        for (int i = 0; i < N; i++) begin
            pe_nx[i] = pe[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == phases_used[0]) begin
                if (desc_q ? (pe[i][WIDTH-1:DATA_WIDTH] < pe[i+1][WIDTH-1:DATA_WIDTH])
                           : (pe[i][WIDTH-1:DATA_WIDTH] > pe[i+1][WIDTH-1:DATA_WIDTH])) begin
                    pe_nx[i]   = pe[i+1];
                    pe_nx[i+1] = pe[i];
                    any_swap   = 1'b1;
                end
            end
        end
    end

    assign phase_end = (phases_used == CNT_W'(N - 1)) || (!any_swap && prev_quiet);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load_fire) state_d = LOAD;
            LOAD:    if (load_last) state_d = SORT;
            SORT:    if (sort_done) state_d = DRAIN;
            DRAIN:   if (out_fire && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // sort_done spends one idle SORT cycle so output starts phases_used+1 after load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q     <= 1'b0;
            load_cnt    <= '0;
            idx         <= '0;
            desc_q      <= 1'b0;
            sort_done   <= 1'b0;
            prev_quiet  <= 1'b0;
            phases_used <= '0;
            for (int i = 0; i < N; i++) begin
                pe[i] <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (load_fire) begin
                pe[load_cnt] <= in_data;
                load_cnt     <= load_last ? '0 : load_cnt + 1'b1;
                if (state_q == IDLE) begin
                    desc_q      <= descend;
                    phases_used <= '0;
                    prev_quiet  <= 1'b0;
                    sort_done   <= 1'b0;
                end
            end
            if ((state_q == SORT) && !sort_done) begin
                for (int i = 0; i < N; i++) begin
                    pe[i] <= pe_nx[i];
                end
                phases_used <= phases_used + 1'b1;
                prev_quiet  <= !any_swap;
                if (phase_end) begin
                    sort_done <= 1'b1;
                end
            end
            if (out_fire) begin
                idx <= out_last ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oet_sort_stream.sv
// Bench for oet_sort_stream: an N=8 instance driven from a vector table and an
// N=64 instance checked against a stable-sort scoreboard.
module tb_oet_sort_stream;

    localparam int W = 12;

    typedef logic [7:0][5:0] row_t;
    typedef struct packed {
        row_t       key;
        logic       desc;
        row_t       exp_key;
        row_t       exp_pay;
        logic [4:0] exp_ph;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, descend, out_valid, out_ready, out_last, busy;
    logic [W-1:0] in_data, out_data;
    logic [6:0]   phases_used;
    logic         in_valid8, in_ready8, descend8, out_valid8, out_ready8, out_last8, busy8;
    logic [W-1:0] in_data8, out_data8;
    logic [3:0]   phases_used8;

    int           applied = 0;
    int           miscompares = 0;
    logic [W-1:0] load_buf [64];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_q8 [$];
    vec_t         vecs [6];

    oet_sort_stream #(.ADDR_WIDTH(6), .DATA_WIDTH(6), .N(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .descend(descend), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .phases_used(phases_used)
    );

    oet_sort_stream #(.ADDR_WIDTH(6), .DATA_WIDTH(6), .N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .descend(descend8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_last(out_last8), .busy(busy8), .phases_used(phases_used8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        row_t r;
        r[0] = a0[5:0]; r[1] = a1[5:0]; r[2] = a2[5:0]; r[3] = a3[5:0];
        r[4] = a4[5:0]; r[5] = a5[5:0]; r[6] = a6[5:0]; r[7] = a7[5:0];
        return r;
    endfunction

    // Stable insertion sort of load_buf by key gives the required output order
    task automatic build_expected(input logic d);
        logic [W-1:0] tmp [64];
        logic [W-1:0] cur;
        int j;
        for (int i = 0; i < 64; i++) tmp[i] = load_buf[i];
        for (int i = 1; i < 64; i++) begin
            cur = tmp[i];
            j = i;
            while (j > 0 && (d ? (tmp[j-1][11:6] < cur[11:6]) : (tmp[j-1][11:6] > cur[11:6]))) begin
                tmp[j] = tmp[j-1];
                j--;
            end
            tmp[j] = cur;
        end
        for (int i = 0; i < 64; i++) exp_q.push_back(tmp[i]);
    endtask

    task automatic apply_stimulus(input logic d, input bit noise);
        int t;
        build_expected(d);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = load_buf[k];
            descend  = (noise && k > 0) ? ~d : d;
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("load_ready_timeout", 0, 1);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_output(input int mode, input bit noise, input int exp_lat, input int exp_ph);
        int  lat;
        int  i;
        int  cyc;
        logic tog;
        logic rdy;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (lat == 1) begin
                check("busy_in_sort", busy, 1);
                check("in_ready_in_sort", in_ready, 0);
            end
            if (noise) begin
                descend  = 1'($urandom);
                in_valid = 1'($urandom);
            end
        end
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        else check("out_valid_seen", out_valid, 1);
        i = 0;
        cyc = 0;
        tog = 1'b1;
        while (i < 64 && cyc < 400) begin
            rdy = (mode == 0) ? 1'b1 : tog;
            tog = ~tog;
            out_ready = rdy;
            if (noise) begin
                descend  = 1'($urandom);
                in_valid = (i < 63) ? 1'($urandom) : 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
                break;
            end
            check("out_valid", out_valid, 1);
            check($sformatf("out_data[%0d]", i), out_data, exp_q[0]);
            check($sformatf("out_last[%0d]", i), out_last, (i == 63));
            if (rdy && out_valid) begin
                void'(exp_q.pop_front());
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        if (i < 64) check("drain_timeout", i, 64);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("in_ready_after_drain", in_ready, 1);
        check("out_valid_after_drain", out_valid, 0);
        check("busy_after_drain", busy, 0);
        if (exp_ph >= 0) check("phases_used", phases_used, exp_ph);
    endtask

    task automatic run_vec8(input int v);
        int t;
        int lat;
        for (int i = 0; i < 8; i++) exp_q8.push_back({vecs[v].exp_key[i], vecs[v].exp_pay[i]});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid8 = 1'b1;
            in_data8  = {vecs[v].key[k], 6'(k)};
            descend8  = vecs[v].desc;
            t = 0;
            while (!in_ready8 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("load8_ready_timeout", 0, 1);
            @(posedge clk);
        end
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid8) break;
        end
        if (vecs[v].exp_ph != 0) begin
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_ph + 1);
            check($sformatf("v%0d_phases", v), phases_used8, vecs[v].exp_ph);
        end
        out_ready8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (exp_q8.size() == 0) break;
            check($sformatf("v%0d_valid[%0d]", v, i), out_valid8, 1);
            check($sformatf("v%0d_word[%0d]", v, i), out_data8, exp_q8.pop_front());
            check($sformatf("v%0d_last[%0d]", v, i), out_last8, (i == 7));
            @(negedge clk);
        end
        out_ready8 = 1'b0;
        check($sformatf("v%0d_in_ready_after", v), in_ready8, 1);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 0; in_data = '0; descend = 0; out_ready = 0;
        in_valid8 = 0; in_data8 = '0; descend8 = 0; out_ready8 = 0;

        vecs[0] = '{key: p8(3,7,1,7,0,5,2,6), desc: 1'b1, exp_key: p8(7,7,6,5,3,2,1,0),
                    exp_pay: p8(1,3,7,5,0,6,2,4), exp_ph: 5'd0};
        vecs[1] = '{key: p8(3,7,1,7,0,5,2,6), desc: 1'b0, exp_key: p8(0,1,2,3,5,6,7,7),
                    exp_pay: p8(4,2,6,0,5,7,1,3), exp_ph: 5'd0};
        vecs[2] = '{key: p8(0,1,2,3,4,5,6,7), desc: 1'b0, exp_key: p8(0,1,2,3,4,5,6,7),
                    exp_pay: p8(0,1,2,3,4,5,6,7), exp_ph: 5'd2};
        vecs[3] = '{key: p8(5,5,5,5,5,5,5,5), desc: 1'b0, exp_key: p8(5,5,5,5,5,5,5,5),
                    exp_pay: p8(0,1,2,3,4,5,6,7), exp_ph: 5'd2};
        vecs[4] = '{key: p8(7,6,5,4,3,2,1,0), desc: 1'b0, exp_key: p8(0,1,2,3,4,5,6,7),
                    exp_pay: p8(7,6,5,4,3,2,1,0), exp_ph: 5'd8};
        vecs[5] = '{key: p8(0,1,2,3,4,5,6,7), desc: 1'b1, exp_key: p8(7,6,5,4,3,2,1,0),
                    exp_pay: p8(7,6,5,4,3,2,1,0), exp_ph: 5'd8};

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_phases", phases_used, 0);
        #10 rst = 1'b1;
        #1 check("in_ready_before_first_edge", in_ready, 0);
        @(negedge clk);
        check("in_ready_after_first_edge", in_ready, 1);

        for (int v = 0; v < 6; v++) run_vec8(v);

        for (int k = 0; k < 64; k++) load_buf[k] = {6'(63 - k), 6'(k)};
        apply_stimulus(1'b0, 1'b0);
        check_output(0, 0, 65, 64);

        for (int k = 0; k < 64; k++) load_buf[k] = {6'(k), 6'(63 - k)};
        apply_stimulus(1'b0, 1'b0);
        check_output(0, 0, 3, 2);

        for (int k = 0; k < 64; k++) load_buf[k] = {6'($urandom_range(0, 15)), 6'(k)};
        apply_stimulus(1'b1, 1'b1);
        check_output(1, 1, -1, -1);

        for (int k = 0; k < 64; k++) load_buf[k] = {6'(63 - k), 6'(k)};
        apply_stimulus(1'b0, 1'b0);
        exp_q.delete();
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midsort_rst_busy", busy, 0);
        check("midsort_rst_in_ready", in_ready, 0);
        check("midsort_rst_out_valid", out_valid, 0);
        check("midsort_rst_out_last", out_last, 0);
        check("midsort_rst_out_data", out_data, 0);
        check("midsort_rst_phases", phases_used, 0);
        #2 rst = 1'b1;
        #1 check("midsort_in_ready_pre_edge", in_ready, 0);
        @(negedge clk);
        check("midsort_in_ready_post_edge", in_ready, 1);
        apply_stimulus(1'b0, 1'b0);
        check_output(1, 0, 65, 64);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/oet_sort_stream.md
OET_SORT_STREAM -- requirements
Module: oet_sort_stream

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: width of sort key field (upper bits of a word).
REQ-002 Parameter DATA_WIDTH, default 6: width of payload field (lower bits of a word).
REQ-003 Parameter N, default 64: number of PEs / words per batch; even, >= 4.
REQ-004 Localparam WIDTH = ADDR_WIDTH + DATA_WIDTH; CNT_W = clog2(N+1).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-007 in_valid  input  1  in_data holds a word to load.
REQ-008 in_ready  output  1  block accepts a load word this cycle.
REQ-009 in_data  input  WIDTH  {key[ADDR_WIDTH-1:0], payload[DATA_WIDTH-1:0]}.
REQ-010 descend  input  1  sort order for the batch: 0 ascending, 1 descending.
REQ-011 out_valid  output  1  out_data holds a sorted word.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 out_data  output  WIDTH  sorted word, index order 0..N-1.
REQ-014 out_last  output  1  high with out_valid on word N-1.
REQ-015 busy  output  1  state is SORT or DRAIN.
REQ-016 phases_used  output  CNT_W  compare-exchange phases run for last batch.

Function
REQ-017 FSM states IDLE, LOAD, SORT, DRAIN; one-hot or binary at implementer's choice.
REQ-018 Load transfer = in_valid && in_ready on a rising edge; in_ready = 1 only in IDLE or LOAD.
REQ-019 k-th transfer (k = 0..N-1) writes PE[k]; IDLE -> LOAD on first transfer; LOAD -> SORT on transfer N-1.
REQ-020 descend sampled on first transfer of a batch and held until batch fully drained; later changes ignored.
REQ-021 phases_used cleared to 0 on first transfer of a batch, otherwise held.
REQ-022 SORT: one phase per cycle; phase p even compares pairs (0,1),(2,3)..; p odd compares (1,2),(3,4)..,(N-3,N-2); PE[0], PE[N-1] idle in odd phases.
REQ-023 Ascending: swap when key(left) > key(right); descending: swap when key(left) < key(right); equal keys never swap; payload moves with key.
REQ-024 phases_used increments by 1 per phase executed.
REQ-025 SORT -> DRAIN after phase N-1 or, earlier, after two consecutive phases with zero swaps (phase 0 and 1 minimum).
REQ-026 DRAIN: out_valid = 1, out_data = PE[idx], idx starts 0, increments on out_valid && out_ready.
REQ-027 out_data and out_last stable while out_valid && !out_ready.
REQ-028 Transfer with out_last -> IDLE same edge; in_ready = 1 next cycle; no bubble required beyond that.
REQ-029 in_valid outside IDLE/LOAD ignored; out_ready outside DRAIN ignored.
REQ-030 Latency: first out_valid exactly phases_used + 1 cycles after the edge accepting word N-1.

Reset
REQ-031 rst = 0 forces immediately, independent of clk: state IDLE, idx 0, load count 0, PE[*] 0, phases_used 0, descend latch 0.
REQ-032 While rst = 0: in_ready 0, out_valid 0, out_last 0, busy 0, out_data 0.
REQ-033 First rising edge after rst returns to 1 sets in_ready = 1; no transfer accepted on that edge.
REQ-034 Reset mid-LOAD, mid-SORT or mid-DRAIN discards batch; no partial output afterwards.

Verification
REQ-035 N=64, descend=0, load word k = {63-k, k}, out_ready=1 -> out word i = {i, 63-i}, out_last on i=63, phases_used = 64.
REQ-036 N=64, already sorted load {k, 63-k} -> output identical to input, phases_used = 2, first out_valid 3 cycles after last load edge.
REQ-037 N=8, descend=1, keys {3,7,1,7,0,5,2,6} with payload = load index -> keys out {7,7,6,5,3,2,1,0}, payloads of the two 7s in order 1 then 3.
REQ-038 N=64, out_ready toggled 1/0 each cycle during DRAIN -> 64 transfers, each word held stable while stalled, in_ready = 1 the cycle after last.
REQ-039 rst driven 0 for 3 ns mid-SORT, between edges -> outputs at reset values immediately; new reverse batch loads and sorts correctly per REQ-035.
REQ-040 descend toggled and in_valid pulsed during SORT/DRAIN -> batch order and contents unchanged, no extra load accepted.
